// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Fixed-latency word memory that answers processor data requests. A request is
// taken in IDLE, held in BUSY for a programmable number of clock edges, and the
// result is presented in RESP until the processor takes it.
//
// Parameters
//   LATENCY     clock edges from request acceptance to rsp_valid rising (1..7)
//   DEPTH_LOG2  log2 of the number of 32-bit words stored
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset (also clears the memory)
//   req_valid   request present
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   req_ready   request can be accepted this cycle (IDLE only)
//   rsp_valid   response present (RESP only)
//   rsp_ready   processor takes the response
//   rsp_rdata   load data, 0 for stores, errors and when no response
//   rsp_err     request was misaligned or out of range
//   txn_count   completed transactions, wrapping at 16 bits
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);

    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    // One bit wider than the address so the limit itself is representable.
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;
    localparam logic [2:0]  CNT_LOAD   = 3'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic                  cap_we;
    logic                  cap_err;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic [31:0]           cap_wdata;
    logic [31:0]           mem [DEPTH];

    logic req_err;
    logic accept;
    logic busy_done;
    logic do_write;

    always_comb begin
        req_err   = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= BYTE_LIMIT);
        accept    = (state == IDLE) && req_valid;
        busy_done = (state == BUSY) && (cnt == 3'd0);
        do_write  = busy_done && cap_we && !cap_err;
        // Gated by reset so the port reads 0 while reset is held.
        req_ready = (state == IDLE) && !reset;
    end

    // Control path: FSM, captured request, response registers, counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            txn_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_we    <= req_we;
                        cap_err   <= req_err;
                        cap_idx   <= req_addr[DEPTH_LOG2+1:2];
                        cap_wdata <= req_wdata;
                        cnt       <= CNT_LOAD;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 3'd0) begin
                        // mem[] here is the pre-edge content, which already
                        // includes any store of the previous transaction.
                        rsp_valid <= 1'b1;
                        rsp_err   <= cap_err;
                        rsp_rdata <= (!cap_we && !cap_err) ? mem[cap_idx] : 32'd0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                        txn_count <= txn_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage array, written once per successful store on the BUSY->RESP edge.
    // NOTE: this memory is deliberately reset word-by-word because the
    // behaviour requires reads after reset to return zero; that forces it into
    // flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (do_write) begin
            mem[cap_idx] <= cap_wdata;
        end
    end

endmodule
